// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 4-master system bus.
// Registered one-hot grants, max-hold preemption, one idle turnaround cycle.
module bus_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       m3_req,
    output logic       m0_get,
    output logic       m1_get,
    output logic       m2_get,
    output logic       m3_get,
    output logic [1:0] owner,
    output logic       bus_busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    // With no hold limit the counter simply parks at all-ones.
    localparam logic [HOLD_W-1:0] HOLD_LIM =
        (MAX_HOLD == 0) ? '1 : HOLD_W'(MAX_HOLD);

    state_t            state;
    state_t            state_nx;
    logic [3:0]        req;
    logic [3:0]        get;
    logic [3:0]        get_nx;
    logic [1:0]        owner_nx;
    logic [1:0]        last_owner;
    logic [1:0]        last_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nx;
    logic              busy_nx;
    logic              win_vld;
    logic [1:0]        win;
    logic [1:0]        cand;
    logic              owner_req;
    logic              others_req;
    logic              preempt;

    assign req = {m3_req, m2_req, m1_req, m0_req};
    assign {m3_get, m2_get, m1_get, m0_get} = get;

    assign owner_req  = |(req & get);
    assign others_req = |(req & ~get);
    assign preempt    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM) && others_req;

    // Scan last+4 down to last+1 so the nearest successor is written last.
    always_comb begin
        win_vld = 1'b0;
        win     = last_owner;
        cand    = last_owner;
        for (int k = 4; k >= 1; k--) begin
            cand = last_owner + 2'(k);
            if (req[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

    always_comb begin
        state_nx = state;
        get_nx   = get;
        owner_nx = owner;
        last_nx  = last_owner;
        hold_nx  = hold_cnt;
        busy_nx  = bus_busy;
        unique case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nx = GRANT;
                    get_nx   = 4'b0001 << win;
                    owner_nx = win;
                    last_nx  = win;
                    hold_nx  = HOLD_W'(1);
                    busy_nx  = 1'b1;
                end
            end
            GRANT: begin
                if (!owner_req || preempt) begin
                    state_nx = IDLE;
                    get_nx   = 4'b0000;
                    hold_nx  = '0;
                    busy_nx  = 1'b0;
                end else if (hold_cnt != HOLD_LIM) begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                get_nx   = 4'b0000;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            get        <= 4'b0000;
            owner      <= 2'd0;
            last_owner <= 2'd3;
            hold_cnt   <= '0;
            bus_busy   <= 1'b0;
        end else begin
            state      <= state_nx;
            get        <= get_nx;
            owner      <= owner_nx;
            last_owner <= last_nx;
            hold_cnt   <= hold_nx;
            bus_busy   <= busy_nx;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus
// randomized request stress against a rule-level reference model.
module tb_bus_arbiter;

    localparam int MAXH     = 16;
    localparam int WAIT_LIM = 3 * (MAXH + 1) + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       m0_get;
    logic       m1_get;
    logic       m2_get;
    logic       m3_get;
    logic [1:0] owner;
    logic       bus_busy;
    logic [3:0] dut_get;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Reference model state
    bit m_busy = 1'b0;
    int m_own  = 0;
    int m_last = 3;
    int m_held = 0;
    int m_wait [4];

    bus_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (req[0]),
        .m1_req   (req[1]),
        .m2_req   (req[2]),
        .m3_req   (req[3]),
        .m0_get   (m0_get),
        .m1_get   (m1_get),
        .m2_get   (m2_get),
        .m3_get   (m3_get),
        .owner    (owner),
        .bus_busy (bus_busy)
    );

    assign dut_get = {m3_get, m2_get, m1_get, m0_get};

    always #5 clk = ~clk;

    // Rule-level model: owner keeps the bus while requesting, leaves
    // after MAX_HOLD cycles if someone else waits, next owner is the
    // first requester after the previous one.
    always @(posedge clk) begin : model
        bit nb;
        int no;
        int nl;
        int nh;
        bit others;
        if (reset) begin
            m_busy <= 1'b0;
            m_own  <= 0;
            m_last <= 3;
            m_held <= 0;
            for (int i = 0; i < 4; i++) m_wait[i] <= 0;
        end else begin
            nb = m_busy;
            no = m_own;
            nl = m_last;
            nh = m_held;
            if (m_busy) begin
                others = 1'b0;
                for (int i = 0; i < 4; i++)
                    if (i != m_own && req[i]) others = 1'b1;
                if (!req[m_own] || (m_held >= MAXH && others)) begin
                    nb = 1'b0;
                    nh = 0;
                end else if (m_held < MAXH) begin
                    nh = m_held + 1;
                end
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    if (!nb && req[(m_last + k) % 4]) begin
                        nb = 1'b1;
                        no = (m_last + k) % 4;
                        nl = no;
                        nh = 1;
                    end
                end
            end
            m_busy <= nb;
            m_own  <= no;
            m_last <= nl;
            m_held <= nh;
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !(nb && no == i)) m_wait[i] <= m_wait[i] + 1;
                else m_wait[i] <= 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0] exp_get;
        if (chk_en) begin
            exp_get = m_busy ? (4'b0001 << m_own) : 4'b0000;
            vectors++;
            if (dut_get !== exp_get || owner !== 2'(m_own)
                || bus_busy !== m_busy || !$onehot0(dut_get)) begin
                miscompares++;
                $display("FAIL cycle t=%0t get=%b exp=%b owner=%0d exp=%0d busy=%b exp=%b",
                         $time, dut_get, exp_get, owner, m_own, bus_busy, m_busy);
            end
            for (int i = 0; i < 4; i++) begin
                if (m_wait[i] > WAIT_LIM) begin
                    miscompares++;
                    $display("FAIL starve t=%0t m%0d waited=%0d limit=%0d",
                             $time, i, m_wait[i], WAIT_LIM);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    logic [3:0] smp [1:85];
    int         n;

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_get", dut_get, 0);
        chk("rst_busy", bus_busy, 0);
        chk("rst_owner", owner, 0);

        reset = 1'b0;
        req   = 4'b0100;
        @(negedge clk);
        chk("m2_get", m2_get, 1);
        chk("m2_owner", owner, 2);
        chk("m2_busy", bus_busy, 1);
        req = 4'b0000;
        @(negedge clk);
        chk("m2_rel", bus_busy, 0);

        // All four requesting from a fresh reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b1111;
        for (int k = 1; k <= 85; k++) begin
            @(negedge clk);
            smp[k] = dut_get;
        end
        req = 4'b0000;
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("rr%0d_first", g), smp[1 + 17 * g], 1 << (g % 4));
            chk($sformatf("rr%0d_last", g), smp[16 + 17 * g], 1 << (g % 4));
            chk($sformatf("rr%0d_idle", g), smp[17 + 17 * g], 0);
        end
        @(negedge clk);

        // Lone requester is never preempted
        req = 4'b0010;
        n   = 0;
        repeat (40) begin
            @(negedge clk);
            n += int'(m1_get);
        end
        req = 4'b0000;
        @(negedge clk);
        chk("m1_hold40", n, 40);
        chk("m1_rel", m1_get, 0);

        // Owner release with a waiter: one idle cycle, then waiter
        req = 4'b0001;
        repeat (5) @(negedge clk);
        req[3] = 1'b1;
        repeat (3) @(negedge clk);
        chk("ho_m0_h8", m0_get, 1);
        req[0] = 1'b0;
        @(negedge clk);
        chk("ho_idle", dut_get, 0);
        @(negedge clk);
        chk("ho_m3", dut_get, 8);
        chk("ho_owner", owner, 3);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Reset during a grant
        req = 4'b0010;
        @(negedge clk);
        chk("rs_m1", m1_get, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rs_drop", dut_get, 0);
        reset = 1'b0;
        req   = 4'b1010;
        @(negedge clk);
        chk("rs_m1_first", dut_get, 2);
        req = 4'b0000;
        @(negedge clk);

        // Random stress
        repeat (10000) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 19) == 0) req[i] = ~req[i];
            reset = ($urandom_range(0, 1999) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        req   = 4'b0000;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
